operand_entry_ctrl: RTL

//  Upstream stage of the seven-segment display path.
//  - Captures two 4-bit operands from the board switches, one per debounced button press.
//  - Drives the operands to the ALU, then registers the ALU output.
//  - Holds op_a, op_b and alu_result stable as the a, b and alu_result inputs of the display.
//  - Sequencing: press 1 loads A, press 2 loads B, the result is latched, press 3 returns to load A.

---
 rtl/operand_entry_ctrl_pkg.sv | 18 +
 rtl/operand_entry_ctrl_button_debouncer.sv | 54 +++++
 rtl/operand_entry_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/operand_entry_ctrl_pkg.sv
// operand_entry_ctrl_pkg
//  Shared types and constants for the operand entry path that feeds the
//  seven-segment display.
//  Contents:
//   DIGIT_W        default operand / result width (one hex digit)
//   entry_state_t  operand entry FSM states; the encoding is what state_o shows
package operand_entry_ctrl_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } entry_state_t;

endpackage

// File: rtl/operand_entry_ctrl_button_debouncer.sv
// button_debouncer
//  Turns a raw, bouncing, asynchronous push-button into a single-cycle press
//  pulse. Intended to be reused for any further buttons on the board.
//  Ports:
//   CLK      in   1  system clock
//   RST      in   1  synchronous, active-high reset
//   btn_raw  in   1  raw mechanical button level
//   press    out  1  registered one-cycle pulse on each debounced 0->1 change
module button_debouncer #(
  parameter int DEBOUNCE_BITS = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic press
);

  localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};

  logic                     sync_1;
  logic                     btn_s;
  logic                     stable;
  logic [DEBOUNCE_BITS-1:0] cnt;

  // Two-flop synchronizer, then a counter that must see the new level for
  // the full window before the stable level follows it. Any return to the
  // stable level restarts the window, so short glitches never get through.
  // Only the rising change of the stable level emits a press.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_1 <= 1'b0;
      btn_s  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      btn_s  <= sync_1;
      press  <= 1'b0;
      if (btn_s != stable) begin
        if (cnt == '1) begin
          stable <= btn_s;
          cnt    <= '0;
          press  <= btn_s;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl
//  Upstream stage of the seven-segment display path. Captures operand A and
//  then operand B from the switches on successive button presses, lets the
//  external ALU settle for a cycle, registers its result and holds all three
//  values for the display until the next press starts a new entry.
//  Ports:
//   CLK         in   1      system clock
//   RST         in   1      synchronous, active-high reset
//   sw          in   WIDTH  operand switches, sampled on a press
//   btn_raw     in   1      raw push-button
//   alu_y       in   WIDTH  combinational ALU output for op_a/op_b
//   op_a        out  WIDTH  registered operand A
//   op_b        out  WIDTH  registered operand B
//   alu_result  out  WIDTH  registered ALU result
//   res_valid   out  1      alu_result belongs to the current op_a/op_b
//   state_o     out  2      current FSM state, for status LEDs
module operand_entry_ctrl
  import operand_entry_ctrl_pkg::*;
#(
  parameter int WIDTH         = DIGIT_W,
  parameter int DEBOUNCE_BITS = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_raw,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] alu_result,
  output logic             res_valid,
  output logic [1:0]       state_o
);

  logic         press;
  entry_state_t state;

  button_debouncer #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_debouncer (
    .CLK    (CLK),
    .RST    (RST),
    .btn_raw(btn_raw),
    .press  (press)
  );

  assign state_o = state;

  // EXEC is a fixed one-cycle wait: op_b was written on the previous edge,
  // so alu_y has had a full cycle to settle before it is captured. A press
  // landing in EXEC is simply dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= LOAD_A;
      op_a       <= '0;
      op_b       <= '0;
      alu_result <= '0;
      res_valid  <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (press) begin
            op_a  <= sw;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (press) begin
            op_b  <= sw;
            state <= EXEC;
          end
        end
        EXEC: begin
          alu_result <= alu_y;
          res_valid  <= 1'b1;
          state      <= SHOW;
        end
        SHOW: begin
          if (press) begin
            res_valid <= 1'b0;
            state     <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule
